// File: rtl/conn_reverse_lookup.sv
// ---------------------------------------------------------------------------
// conn_reverse_lookup
//
// Purpose:
//   Reverse-direction companion to the connection table. A connection id
//   {way, hash} is mapped back to the 32-bit connection key stored for it.
//   The block keeps its own {valid, key} table, written by the control path
//   on activate/deactivate, and clears that table after every reset.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   s00_axis_rv_lookup_*      lookup request (valid, id, ready)
//   m00_axis_rv_lookup_*      lookup response (valid, ready, hit, key, id)
//   s01_axis_upd_*            table update (valid, id, key, activate, ready)
//   init_done                 1 once the post-reset table clear has finished
//   stat_hits, stat_misses    response handshake counters
//
// Handshake semantics (all three streams):
//   A beat transfers on a rising clk edge where valid && ready are both 1.
//   A source holds valid and its payload stable until the transfer; ready
//   may change freely. The response stream keeps hit/key/id stable while
//   valid && !ready.
//
// Configuration:
//   CONN_REVERSE_LOOKUP_STATS_EN - when defined, stat_hits / stat_misses
//   count response handshakes with hit=1 / hit=0 (wrapping, cleared on
//   reset). When undefined both outputs are tied to 0.
// ---------------------------------------------------------------------------
module conn_reverse_lookup #(
    parameter int KEY_WIDTH  = 32,
    parameter int WAYS       = 4,
    parameter int HASH_WIDTH = 16,
    parameter int RESP_WIDTH = HASH_WIDTH + $clog2(WAYS),
    parameter int DEPTH      = 1 << RESP_WIDTH,
    parameter int OUT_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  s00_axis_rv_lookup_valid,
    input  logic [RESP_WIDTH-1:0] s00_axis_rv_lookup_id,
    output logic                  s00_axis_rv_lookup_ready,

    output logic                  m00_axis_rv_lookup_valid,
    input  logic                  m00_axis_rv_lookup_ready,
    output logic                  m00_axis_rv_lookup_hit,
    output logic [KEY_WIDTH-1:0]  m00_axis_rv_lookup_key,
    output logic [RESP_WIDTH-1:0] m00_axis_rv_lookup_id,

    input  logic                  s01_axis_upd_valid,
    input  logic [RESP_WIDTH-1:0] s01_axis_upd_id,
    input  logic [KEY_WIDTH-1:0]  s01_axis_upd_key,
    input  logic                  s01_axis_upd_activate,
    output logic                  s01_axis_upd_ready,

    output logic                  init_done,
    output logic [31:0]           stat_hits,
    output logic [31:0]           stat_misses
);

    localparam int ENTRY_W = KEY_WIDTH + 1;             // {valid, key}
    localparam int PTR_W   = $clog2(OUT_DEPTH);
    localparam int CNT_W   = $clog2(OUT_DEPTH) + 1;     // holds 0..OUT_DEPTH
    localparam logic [RESP_WIDTH-1:0] LAST_ENTRY = RESP_WIDTH'(DEPTH - 1);

    // -----------------------------------------------------------------------
    // Control FSM: INIT sweeps the table, RUN is normal operation.
    // init_done is registered alongside the state so it is glitch-free and
    // doubles as the observable state indicator.
    // -----------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                state;
    logic [RESP_WIDTH-1:0] clr_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_INIT;
            clr_cnt   <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    clr_cnt <= clr_cnt + RESP_WIDTH'(1);
                    if (clr_cnt == LAST_ENTRY) begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    state     <= ST_RUN;
                    init_done <= 1'b1;
                end
                default: begin
                    state     <= ST_INIT;
                    clr_cnt   <= '0;
                    init_done <= 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Table write port. During INIT the sweep owns the port; in RUN the
    // update stream is always accepted. Deactivation stores a zero key so a
    // stale key can never leak even if the hit mask were bypassed.
    // -----------------------------------------------------------------------
    logic                  upd_fire;
    logic                  mem_we;
    logic [RESP_WIDTH-1:0] mem_waddr;
    logic [ENTRY_W-1:0]    mem_wdata;

    assign s01_axis_upd_ready = init_done;
    assign upd_fire           = s01_axis_upd_valid && s01_axis_upd_ready;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = s01_axis_upd_id;
        mem_wdata = '0;
        if (state == ST_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = clr_cnt;
            mem_wdata = '0;
        end else if (upd_fire) begin
            mem_we    = 1'b1;
            mem_waddr = s01_axis_upd_id;
            mem_wdata = s01_axis_upd_activate ? {1'b1, s01_axis_upd_key} : '0;
        end
    end

    // -----------------------------------------------------------------------
    // Lookup pipeline.
    //   edge T   : request accepted, id captured in stage 1
    //   edge T+1 : table read into rd_data, stage 2 valid
    //   edge T+2 : result written into the output buffer
    // The id is used as the table address directly: its upper bits are the
    // way and its lower HASH_WIDTH bits the hash, so every id is in range.
    // Because the read happens one edge after acceptance, an update accepted
    // together with the request is already in the table (write-first), while
    // any later update lands after the read and cannot affect it.
    // -----------------------------------------------------------------------
    logic                  lookup_fire;
    logic                  p1_valid;
    logic [RESP_WIDTH-1:0] p1_id;
    logic                  p2_valid;
    logic [RESP_WIDTH-1:0] p2_id;
    logic [ENTRY_W-1:0]    rd_data;

    logic [ENTRY_W-1:0]    mem [DEPTH];

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        if (p1_valid) begin
            rd_data <= mem[p1_id];
        end
    end

    assign lookup_fire = s00_axis_rv_lookup_valid && s00_axis_rv_lookup_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1_valid <= 1'b0;
            p1_id    <= '0;
            p2_valid <= 1'b0;
            p2_id    <= '0;
        end else begin
            p1_valid <= lookup_fire;
            p1_id    <= s00_axis_rv_lookup_id;
            p2_valid <= p1_valid;
            p2_id    <= p1_id;
        end
    end

    // -----------------------------------------------------------------------
    // Output buffer (circular FIFO, head drives m00 directly).
    // Credit: a request is only accepted while requests in the pipeline plus
    // buffered entries leave room, so the buffer can never overflow and the
    // pipeline never has to stall.
    // -----------------------------------------------------------------------
    logic                  buf_hit [OUT_DEPTH];
    logic [KEY_WIDTH-1:0]  buf_key [OUT_DEPTH];
    logic [RESP_WIDTH-1:0] buf_id  [OUT_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [CNT_W:0]        credit_used;
    logic                  push;
    logic                  pop;
    logic                  push_hit;
    logic [KEY_WIDTH-1:0]  push_key;

    assign credit_used = {{CNT_W{1'b0}}, p1_valid}
                       + {{CNT_W{1'b0}}, p2_valid}
                       + {1'b0, count};

    assign s00_axis_rv_lookup_ready = init_done
                                   && (credit_used < (CNT_W + 1)'(OUT_DEPTH));

    assign push     = p2_valid;
    assign pop      = m00_axis_rv_lookup_valid && m00_axis_rv_lookup_ready;
    assign push_hit = rd_data[KEY_WIDTH];
    assign push_key = push_hit ? rd_data[KEY_WIDTH-1:0] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < OUT_DEPTH; i++) begin
                buf_hit[i] <= 1'b0;
                buf_key[i] <= '0;
                buf_id[i]  <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                buf_hit[wr_ptr] <= push_hit;
                buf_key[wr_ptr] <= push_key;
                buf_id[wr_ptr]  <= p2_id;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // count is reset asynchronously, so m00 valid drops the moment rst rises
    assign m00_axis_rv_lookup_valid = (count != '0);
    assign m00_axis_rv_lookup_hit   = buf_hit[rd_ptr];
    assign m00_axis_rv_lookup_key   = buf_key[rd_ptr];
    assign m00_axis_rv_lookup_id    = buf_id[rd_ptr];

    // -----------------------------------------------------------------------
    // Optional response statistics
    // -----------------------------------------------------------------------
`ifdef CONN_REVERSE_LOOKUP_STATS_EN
    logic [31:0] hits_q;
    logic [31:0] misses_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else if (pop) begin
            if (m00_axis_rv_lookup_hit) begin
                hits_q <= hits_q + 32'd1;
            end else begin
                misses_q <= misses_q + 32'd1;
            end
        end
    end

    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;
`else
    assign stat_hits   = 32'd0;
    assign stat_misses = 32'd0;
`endif

endmodule

// File: tb/tb_conn_reverse_lookup.sv
// ---------------------------------------------------------------------------
// tb_conn_reverse_lookup
//
// Self-checking bench for conn_reverse_lookup with a 64-entry table.
// The reference model is a plain array of {valid, key} per id. Accepted
// lookups push their expected response into exp_q; a separate monitor pops
// and compares every response handshake, so ordering, loss and duplication
// are all caught. Inputs change 1 time unit after the rising edge; all
// sampling happens on the falling edge.
// ---------------------------------------------------------------------------
module tb_conn_reverse_lookup;

    localparam int KW    = 32;
    localparam int HW    = 4;
    localparam int NWAYS = 4;
    localparam int RW    = HW + $clog2(NWAYS);
    localparam int DEPTH = 1 << RW;
    localparam int OD    = 4;
    localparam int EW    = 1 + KW + RW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic          lk_valid;
    logic [RW-1:0] lk_id;
    logic          lk_ready;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_hit;
    logic [KW-1:0] rsp_key;
    logic [RW-1:0] rsp_id;
    logic          upd_valid;
    logic [RW-1:0] upd_id;
    logic [KW-1:0] upd_key;
    logic          upd_act;
    logic          upd_ready;
    logic          init_done;
    logic [31:0]   stat_hits;
    logic [31:0]   stat_misses;

    conn_reverse_lookup #(
        .KEY_WIDTH (KW),
        .WAYS      (NWAYS),
        .HASH_WIDTH(HW),
        .RESP_WIDTH(RW),
        .DEPTH     (DEPTH),
        .OUT_DEPTH (OD)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .s00_axis_rv_lookup_valid(lk_valid),
        .s00_axis_rv_lookup_id   (lk_id),
        .s00_axis_rv_lookup_ready(lk_ready),
        .m00_axis_rv_lookup_valid(rsp_valid),
        .m00_axis_rv_lookup_ready(rsp_ready),
        .m00_axis_rv_lookup_hit  (rsp_hit),
        .m00_axis_rv_lookup_key  (rsp_key),
        .m00_axis_rv_lookup_id   (rsp_id),
        .s01_axis_upd_valid      (upd_valid),
        .s01_axis_upd_id         (upd_id),
        .s01_axis_upd_key        (upd_key),
        .s01_axis_upd_activate   (upd_act),
        .s01_axis_upd_ready      (upd_ready),
        .init_done               (init_done),
        .stat_hits               (stat_hits),
        .stat_misses             (stat_misses)
    );

    // ---------------- checking infrastructure ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic          model_valid [DEPTH];
    logic [KW-1:0] model_key   [DEPTH];
    logic [EW-1:0] exp_q[$];
    int            pop_cyc_q[$];
    int            exp_hits   = 0;
    int            exp_misses = 0;

    task automatic reset_model();
        for (int i = 0; i < DEPTH; i++) begin
            model_valid[i] = 1'b0;
            model_key[i]   = '0;
        end
        exp_q.delete();
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    // Input monitor: updates are applied before a same-cycle lookup reads
    // the model, which gives the write-first collision behaviour.
    always @(negedge clk) begin
        if (!rst) begin
            if (upd_valid && upd_ready) begin
                model_valid[upd_id] = upd_act;
                model_key[upd_id]   = upd_act ? upd_key : '0;
            end
            if (lk_valid && lk_ready) begin
                exp_q.push_back({model_valid[lk_id],
                                 model_valid[lk_id] ? model_key[lk_id] : {KW{1'b0}},
                                 lk_id});
            end
        end
    end

    // Output monitor
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (!rst && rsp_valid && rsp_ready) begin
            pop_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("unexpected_response", 64'(rsp_id), 64'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_id",  64'(rsp_id),  64'(e[RW-1:0]));
                chk("rsp_hit", 64'(rsp_hit), 64'(e[EW-1]));
                chk("rsp_key", 64'(rsp_key), 64'(e[RW +: KW]));
                if (e[EW-1]) exp_hits++;
                else         exp_misses++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_init();
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            chk("init_phase_outputs", {61'd0, init_done, lk_ready, upd_ready}, 64'd0);
        end
        @(negedge clk);
        chk("init_done_run", 64'(init_done), 64'd1);
        chk("upd_ready_run", 64'(upd_ready), 64'd1);
    endtask

    task automatic do_upd(input logic [RW-1:0] id, input logic [KW-1:0] key, input logic act);
        @(posedge clk); #1;
        upd_valid = 1'b1; upd_id = id; upd_key = key; upd_act = act;
        @(negedge clk);
        chk("upd_ready", 64'(upd_ready), 64'd1);
        @(posedge clk); #1;
        upd_valid = 1'b0;
    endtask

    task automatic do_lookup(input logic [RW-1:0] id);
        bit acc = 1'b0;
        @(posedge clk); #1;
        lk_valid = 1'b1; lk_id = id;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (lk_ready) begin
                acc = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("lookup_accepted", 64'(acc), 64'd1);
        @(posedge clk); #1;
        lk_valid = 1'b0;
    endtask

    // Called right after do_lookup into an empty buffer with rsp_ready=1:
    // the response must first appear two edges after the accepting edge.
    task automatic check_latency();
        @(negedge clk);
        @(negedge clk);
        chk("latency_not_early", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        chk("latency_on_time", 64'(rsp_valid), 64'd1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        @(negedge clk);
        chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int            next;
        int            guard;
        bit            lk_acc;
        logic [31:0]   exp_stat_h;
        logic [31:0]   exp_stat_m;

        lk_valid = 1'b0; lk_id = '0; rsp_ready = 1'b1;
        upd_valid = 1'b0; upd_id = '0; upd_key = '0; upd_act = 1'b0;
        reset_model();

        // reset state
        #12;
        chk("reset_outputs", {58'd0, init_done, lk_ready, upd_ready, rsp_valid, rsp_hit, 1'b0}, 64'd0);
        chk("reset_key", 64'(rsp_key), 64'd0);
        chk("reset_stats", {stat_hits, stat_misses}, 64'd0);

        @(posedge clk); #1;
        rst = 1'b0;
        check_init();

        // lookup of a cleared entry
        do_lookup(6'h2A);
        check_latency();
        wait_drain();

        // activate then lookup, then deactivate then lookup
        do_upd(6'h13, 32'hDEADBEEF, 1'b1);
        do_lookup(6'h13);
        check_latency();
        wait_drain();
        do_upd(6'h13, 32'hCAFEF00D, 1'b0);
        do_lookup(6'h13);
        wait_drain();

        // same-cycle update and lookup of one id
        @(posedge clk); #1;
        upd_valid = 1'b1; upd_id = 6'h05; upd_key = 32'h12345678; upd_act = 1'b1;
        lk_valid  = 1'b1; lk_id  = 6'h05;
        @(negedge clk);
        chk("collision_lk_ready", 64'(lk_ready), 64'd1);
        @(posedge clk); #1;
        upd_valid = 1'b0; lk_valid = 1'b0;
        // update accepted after the read must not affect it
        upd_valid = 1'b1; upd_id = 6'h05; upd_key = 32'h0BAD0BAD; upd_act = 1'b1;
        @(posedge clk); #1;
        upd_valid = 1'b0;
        wait_drain();

        // backpressure: only OUT_DEPTH requests may be in the block
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        next = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            lk_valid = 1'b1; lk_id = RW'(next);
            @(negedge clk);
            if (lk_ready) next++;
        end
        chk("bp_accepted", 64'(next), 64'd4);
        chk("bp_ready_low", 64'(lk_ready), 64'd0);
        chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
        pop_cyc_q.delete();
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        lk_id = RW'(next);
        guard = 0;
        while (next < 10 && guard < 100) begin
            @(negedge clk);
            if (lk_ready) next++;
            @(posedge clk); #1;
            lk_id = RW'(next);
            guard++;
        end
        lk_valid = 1'b0;
        wait_drain();
        chk("bp_rsp_count", 64'(pop_cyc_q.size()), 64'd10);
        if (pop_cyc_q.size() == 10)
            chk("bp_throughput", 64'(pop_cyc_q[9] - pop_cyc_q[0]), 64'd9);

        // reset with buffered responses
        do_upd(6'h21, 32'hA5A5_0001, 1'b1);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        do_lookup(6'h01);
        do_lookup(6'h02);
        do_lookup(6'h03);
        repeat (4) @(negedge clk);
        chk("midrst_buffered", 64'(rsp_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_valid_drop", 64'(rsp_valid), 64'd0);
        chk("midrst_init_done", 64'(init_done), 64'd0);
        chk("midrst_stats", {stat_hits, stat_misses}, 64'd0);
        reset_model();
        @(posedge clk); #1;
        rst = 1'b0;
        rsp_ready = 1'b1;
        check_init();
        do_lookup(6'h05);
        do_lookup(6'h21);
        wait_drain();

        // randomized traffic against the model
        lk_acc = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            if (!lk_valid || lk_acc) begin
                lk_valid = ($urandom_range(0, 2) != 0);
                lk_id    = RW'($urandom_range(0, 11));
            end
            upd_valid = ($urandom_range(0, 2) == 0);
            upd_id    = RW'($urandom_range(0, 11));
            upd_key   = $urandom;
            upd_act   = ($urandom_range(0, 2) != 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            lk_acc = lk_valid && lk_ready;
        end
        @(posedge clk); #1;
        lk_valid = 1'b0; upd_valid = 1'b0; rsp_ready = 1'b1;
        wait_drain();
        repeat (2) @(negedge clk);

`ifdef CONN_REVERSE_LOOKUP_STATS_EN
        exp_stat_h = 32'(exp_hits);
        exp_stat_m = 32'(exp_misses);
`else
        exp_stat_h = 32'd0;
        exp_stat_m = 32'd0;
`endif
        chk("stat_hits",   64'(stat_hits),   64'(exp_stat_h));
        chk("stat_misses", 64'(stat_misses), 64'(exp_stat_m));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
